// File: rtl/acc_exec_unit.sv
// Accumulator sequencing stage around the external 8-bit ALU: IDLE -> EXEC -> RESP.
// Optional zero flag register enabled by defining ACC_ZFLAG_EN.
module acc_exec_unit #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] alu_ac,
  output logic [WIDTH-1:0] alu_dr,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_ac,
  output logic             e_flag,
  output logic             z_flag,
  output logic             illegal
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_SHL = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_CMA = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_LDA = OPW'(4'b1000);
  localparam logic [OPW-1:0] OP_CLA = OPW'(4'b1001);
  localparam logic [OPW-1:0] OP_CLE = OPW'(4'b1010);
  localparam logic [OPW-1:0] OP_CME = OPW'(4'b1011);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic [OPW-1:0]   op_reg;
  logic [WIDTH-1:0] ac_reg, dr_reg, ac_next;
  logic [2:0]       sel_reg, sel_dec;
  logic             e_reg, e_next, illegal_reg, illegal_next;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    sel_dec = 3'b000;
    case (cmd_op)
      OP_SUB:  sel_dec = 3'b001;
      OP_XOR:  sel_dec = 3'b010;
      OP_SHL:  sel_dec = 3'b011;
      OP_CMA:  sel_dec = 3'b110;
      default: sel_dec = 3'b000;
    endcase
  end

  // ADD carry: ac + dr overflows exactly when ac > 255 - dr, i.e. ac > ~dr.
  always_comb begin
    ac_next      = ac_reg;
    e_next       = e_reg;
    illegal_next = illegal_reg;
    case (op_reg)
      OP_ADD: begin ac_next = alu_result; e_next = (ac_reg > ~dr_reg); end
      OP_SUB: begin ac_next = alu_result; e_next = (ac_reg >= dr_reg); end
      OP_XOR: ac_next = alu_result;
      OP_SHL: begin ac_next = alu_result; e_next = ac_reg[WIDTH-1]; end
      OP_CMA: ac_next = alu_result;
      OP_LDA: ac_next = dr_reg;
      OP_CLA: ac_next = '0;
      OP_CLE: e_next = 1'b0;
      OP_CME: e_next = ~e_reg;
      default: illegal_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= '0;
      dr_reg      <= '0;
      sel_reg     <= 3'b000;
      ac_reg      <= '0;
      e_reg       <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      if (accept) begin
        op_reg  <= cmd_op;
        dr_reg  <= cmd_operand;
        sel_reg <= sel_dec;
      end
      if (state_reg == EXEC) begin
        ac_reg      <= ac_next;
        e_reg       <= e_next;
        illegal_reg <= illegal_next;
      end
    end
  end

`ifdef ACC_ZFLAG_EN
  logic z_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  z_reg <= 1'b0;
    else if (state_reg == EXEC)  z_reg <= (ac_next == '0);
  end
  assign z_flag = z_reg;
`else
  assign z_flag = 1'b0;
`endif

  assign alu_ac  = ac_reg;
  assign alu_dr  = dr_reg;
  assign alu_sel = sel_reg;
  assign resp_ac = ac_reg;
  assign e_flag  = e_reg;
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_acc_exec_unit.sv
// Directed self-checking bench for acc_exec_unit with a behavioural ALU model.
// Z-flag expectations follow ACC_ZFLAG_EN.
`timescale 1ns/1ps
module tb_acc_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, resp_valid, resp_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_operand, alu_ac, alu_dr, alu_result, resp_ac;
  logic [2:0] alu_sel;
  logic       e_flag, z_flag, illegal;

  int checks = 0;
  int errors = 0;

  acc_exec_unit #(.WIDTH(8), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_sel(alu_sel), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ac(resp_ac),
    .e_flag(e_flag), .z_flag(z_flag), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference ALU: fixed selector encoding.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_ac + alu_dr;
      3'b001:  alu_result = alu_ac - alu_dr;
      3'b010:  alu_result = alu_ac ^ alu_dr;
      3'b011:  alu_result = {alu_ac[6:0], 1'b0};
      3'b110:  alu_result = ~alu_ac;
      default: alu_result = alu_ac;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic zexp(input logic [7:0] ac);
`ifdef ACC_ZFLAG_EN
    return (ac == 8'h00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command with resp_ready high; entered and left 1ns after a rising edge in IDLE.
  task automatic do_cmd(input string name, input logic [3:0] op, input logic [7:0] opnd,
                        input logic [7:0] exp_ac, input logic exp_e, input logic exp_ill);
    cmd_valid = 1'b1; cmd_op = op; cmd_operand = opnd; resp_ready = 1'b1;
    check({name, " cmd_ready idle"}, cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    check({name, " resp_valid exec"}, resp_valid, 1'b0);
    check({name, " dr"}, alu_dr, opnd);
    step();
    check({name, " resp_valid"}, resp_valid, 1'b1);
    check({name, " resp_ac"}, resp_ac, exp_ac);
    check({name, " e_flag"}, e_flag, exp_e);
    check({name, " z_flag"}, z_flag, zexp(exp_ac));
    check({name, " illegal"}, illegal, exp_ill);
    $display("cmd %s op=%b operand=%02h -> ac=%02h e=%b z=%b ill=%b",
             name, op, opnd, resp_ac, e_flag, z_flag, illegal);
    step();
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_operand = 8'h00; resp_ready = 1'b0;
    #23;
    check("rst resp_valid", resp_valid, 1'b0);
    check("rst ac", alu_ac, 8'h00);
    check("rst dr", alu_dr, 8'h00);
    check("rst sel", alu_sel, 3'b000);
    check("rst e", e_flag, 1'b0);
    check("rst z", z_flag, 1'b0);
    check("rst illegal", illegal, 1'b0);
    rst_n = 1'b1;
    step();
    check("post-rst cmd_ready", cmd_ready, 1'b1);

    do_cmd("LDA", 4'b1000, 8'h37, 8'h37, 1'b0, 1'b0);
    do_cmd("ADD", 4'b0000, 8'h05, 8'h3C, 1'b0, 1'b0);
    do_cmd("ADD", 4'b0000, 8'hFF, 8'h3B, 1'b1, 1'b0);
    do_cmd("SUB", 4'b0001, 8'h40, 8'hFB, 1'b0, 1'b0);
    do_cmd("SHL", 4'b0011, 8'h00, 8'hF6, 1'b1, 1'b0);
    do_cmd("CMA", 4'b0110, 8'h00, 8'h09, 1'b1, 1'b0);
    do_cmd("CME", 4'b1011, 8'h00, 8'h09, 1'b0, 1'b0);

    // Stalled response: ADD 0x01 held 4 cycles while an LDA 0x09 waits on cmd_valid.
    cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_operand = 8'h01; resp_ready = 1'b0;
    step();
    cmd_op = 4'b1000; cmd_operand = 8'h09;
    check("stall exec cmd_ready", cmd_ready, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("stall resp_valid", resp_valid, 1'b1);
      check("stall resp_ac", resp_ac, 8'h0A);
      check("stall cmd_ready", cmd_ready, 1'b0);
      check("stall dr", alu_dr, 8'h01);
      $display("stall cycle %0d resp_valid=%b resp_ac=%02h cmd_ready=%b", i, resp_valid, resp_ac, cmd_ready);
      step();
    end
    resp_ready = 1'b1;
    check("stall release resp_valid", resp_valid, 1'b1);
    step();
    check("post-handshake resp_valid", resp_valid, 1'b0);
    check("post-handshake cmd_ready", cmd_ready, 1'b1);
    check("post-handshake ac", alu_ac, 8'h0A);
    check("post-handshake dr", alu_dr, 8'h01);
    step();
    cmd_valid = 1'b0;
    check("queued LDA accepted", cmd_ready, 1'b0);
    check("queued LDA dr", alu_dr, 8'h09);
    step();
    check("queued LDA resp_ac", resp_ac, 8'h09);
    check("queued LDA e", e_flag, 1'b0);
    $display("queued cmd LDA -> ac=%02h e=%b", resp_ac, e_flag);
    step();

    do_cmd("ILL", 4'b0100, 8'h55, 8'h09, 1'b0, 1'b1);
    do_cmd("CLA", 4'b1001, 8'h00, 8'h00, 1'b0, 1'b1);
    do_cmd("ADD", 4'b0000, 8'h01, 8'h01, 1'b0, 1'b1);
    do_cmd("ADD", 4'b0000, 8'hFF, 8'h00, 1'b1, 1'b1);
    do_cmd("CLE", 4'b1010, 8'h00, 8'h00, 1'b0, 1'b1);
    do_cmd("ADD", 4'b0000, 8'hF8, 8'hF8, 1'b0, 1'b1);
    do_cmd("CME", 4'b1011, 8'h00, 8'hF8, 1'b1, 1'b1);

    // Asynchronous reset during EXEC of ADD 0x10.
    cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_operand = 8'h10; resp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("rst-mid exec", resp_valid, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst-mid ac", alu_ac, 8'h00);
    check("rst-mid e", e_flag, 1'b0);
    check("rst-mid illegal", illegal, 1'b0);
    check("rst-mid resp_valid", resp_valid, 1'b0);
    $display("async reset mid-EXEC ac=%02h e=%b ill=%b", alu_ac, e_flag, illegal);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post-rst no stale resp", resp_valid, 1'b0);
      check("post-rst cmd_ready", cmd_ready, 1'b1);
    end

    do_cmd("LDA", 4'b1000, 8'h5A, 8'h5A, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
